// File: rtl/oam_dma_if.sv
// rtl/oam_dma_if.sv - CPU, shared-bus and OAM signal bundle for oam_dma
// master is the DMA engine side; slave is the CPU/memory/OAM side.
interface oam_dma_if;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic [15:0] mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  oam_a;
  logic [7:0]  oam_dout;
  logic        oam_wr;
  logic        dma_active;

  modport master (
    input  cpu_a, cpu_dout, cpu_rd, cpu_wr, mem_din,
    output cpu_din, mem_a, mem_dout, mem_rd, mem_wr,
    output oam_a, oam_dout, oam_wr, dma_active
  );

  modport slave (
    output cpu_a, cpu_dout, cpu_rd, cpu_wr, mem_din,
    input  cpu_din, mem_a, mem_dout, mem_rd, mem_wr,
    input  oam_a, oam_dout, oam_wr, dma_active
  );
endinterface

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - 160-byte OAM DMA engine sharing the CPU memory bus
// Copies {src,00..9F} to OAM one byte per 4-clk M-cycle, gating CPU bus access meanwhile.
module oam_dma (
  input  logic      clk,
  input  logic      rst,
  oam_dma_if.master bus
);
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_START = 2'd1;
  localparam logic [1:0]  ST_XFER  = 2'd2;
  localparam logic [7:0]  LAST_IDX = 8'd159;
  localparam logic [15:0] DMA_REG  = 16'hFF46;

  logic [1:0] phase;
  logic [1:0] state;
  logic [7:0] src_hi;
  logic [7:0] idx;
  logic [7:0] data_latch;
  logic       cpu_wr_q;

  logic       reg_wr;
  logic       active;
  logic       dma_slot;
  logic       cpu_allowed;
  logic [7:0] src_eff;

  assign reg_wr   = bus.cpu_wr && !cpu_wr_q && (bus.cpu_a == DMA_REG);
  // Echo-RAM pages E0-FF fold back onto C0-DF.
  assign src_eff  = (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
  assign active   = (state == ST_START) || (state == ST_XFER);
  // DMA owns the bus for the first half of each M-cycle; permitted CPU
  // accesses use it in the second half.
  assign dma_slot = (state == ST_XFER) && !phase[1];
  assign cpu_allowed = !active || (bus.cpu_a == DMA_REG) ||
                       ((bus.cpu_a >= 16'hFF80) && (bus.cpu_a <= 16'hFFFE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= 2'd0;
      state      <= ST_IDLE;
      src_hi     <= 8'h00;
      idx        <= 8'h00;
      data_latch <= 8'h00;
      cpu_wr_q   <= 1'b0;
    end else begin
      phase    <= phase + 2'd1;
      cpu_wr_q <= bus.cpu_wr;
      if (reg_wr) begin
        src_hi <= bus.cpu_dout;
        state  <= ST_START;
        idx    <= 8'h00;
      end else begin
        case (state)
          ST_START: begin
            if (phase == 2'd3) begin
              state <= ST_XFER;
              idx   <= 8'h00;
            end
          end
          ST_XFER: begin
            if (phase == 2'd2) begin
              data_latch <= bus.mem_din;
            end
            if (phase == 2'd3) begin
              if (idx == LAST_IDX) begin
                state <= ST_IDLE;
                idx   <= 8'h00;
              end else begin
                idx <= idx + 8'd1;
              end
            end
          end
          ST_IDLE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    bus.mem_a      = dma_slot ? {src_eff, idx} : bus.cpu_a;
    bus.mem_rd     = dma_slot || (bus.cpu_rd && cpu_allowed);
    bus.mem_wr     = !dma_slot && bus.cpu_wr && cpu_allowed;
    bus.mem_dout   = bus.cpu_dout;
    bus.oam_a      = idx;
    bus.oam_dout   = data_latch;
    bus.oam_wr     = (state == ST_XFER) && (phase == 2'd3);
    bus.dma_active = active;
    if (bus.cpu_a == DMA_REG) begin
      bus.cpu_din = src_hi;
    end else if (cpu_allowed) begin
      bus.cpu_din = bus.mem_din;
    end else begin
      bus.cpu_din = 8'hFF;
    end
  end
endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have clock and reset: clk (clock); rst (reset, asynchronous, active-high).
REQ-002 SHALL have ports, name direction width meaning:
 clk  in  1  system clock, 4 clk per M-cycle
 rst  in  1  async active-high reset
 cpu_a  in  16  CPU address
 cpu_dout  in  8  CPU write data
 cpu_rd  in  1  CPU read strobe
 cpu_wr  in  1  CPU write strobe
 cpu_din  out  8  read data returned to CPU
 mem_a  out  16  shared bus address
 mem_dout  out  8  shared bus write data
 mem_din  in  8  shared bus read data
 mem_rd  out  1  shared bus read strobe
 mem_wr  out  1  shared bus write strobe
 oam_a  out  8  OAM byte index
 oam_dout  out  8  OAM write data
 oam_wr  out  1  OAM write strobe
 dma_active  out  1  high while DMA owns the shared bus
REQ-003 SHALL have no parameters; transfer length fixed at 160 bytes.

Function
REQ-004 SHALL keep free-running 2-bit phase counter, reset 0, incrementing every clk; phase 0 aligns with CPU M-cycle start (same reset).
REQ-005 SHALL hold 8-bit register src_hi, written on rising edge of cpu_wr with cpu_a==16'hFF46, from cpu_dout; CPU read of FF46 returns src_hi.
REQ-006 SHALL implement states IDLE, START, XFER.
REQ-007 IDLE: on FF46 write -> START; START: wait until phase==3 -> XFER with idx=0 at next phase 0.
REQ-008 XFER: one byte per M-cycle: phase 0 mem_a={src_eff,idx}, mem_rd=1; phase 2 latch mem_din; phase 3 oam_a=idx, oam_dout=latched byte, oam_wr=1 for that clk, then idx+1.
REQ-009 src_eff SHALL be src_hi-8'h20 when src_hi>=8'hE0, else src_hi.
REQ-010 After write of idx 159 (8-bit idx, no wrap past 159), SHALL return to IDLE at next phase 0.
REQ-011 dma_active SHALL be 1 in START and XFER only.
REQ-012 While dma_active==0, SHALL pass CPU through: mem_a=cpu_a, mem_rd=cpu_rd, mem_wr=cpu_wr, mem_dout=cpu_dout, cpu_din=mem_din (except FF46 read).
REQ-013 While dma_active==1, CPU access to FF80-FFFE and FF46 SHALL pass through/serve normally; other CPU reads return 8'hFF, other CPU writes SHALL be dropped (mem_wr=0 for them).
REQ-014 DMA SHALL drive mem_wr=0 at all times; mem_rd high only in XFER phase 0-1 or CPU pass-through.
REQ-015 FF46 write during START or XFER SHALL restart: reload src_hi, -> START, idx=0; partial OAM content left as is.
REQ-016 oam_wr SHALL pulse exactly 160 times per completed transfer, never outside XFER.

Reset
REQ-017 On rst: state IDLE, phase 0, idx 0, src_hi 8'h00, dma_active 0, mem_rd/mem_wr/oam_wr 0, oam_a/oam_dout 0, latch 0.
REQ-018 rst asserted mid-transfer SHALL abort immediately; no further oam_wr until a new FF46 write.

Verification
REQ-019 Write FF46=8'hC1, memory C100+i=i -> 160 oam_wr pulses, oam_a 0..159, oam_dout 0..159, dma_active drops after last.
REQ-020 Write FF46=8'hE2 -> mem_a during XFER runs C200..C29F.
REQ-021 During XFER CPU reads 8000 -> cpu_din 8'hFF; CPU writes FF85 -> passes (mem_wr=1, mem_a FF85); CPU writes C000 -> mem_wr stays 0.
REQ-022 Write FF46=8'hC0, at idx 50 write FF46=8'hD0 -> idx restarts 0, mem_a D000.., 160 further oam_wr pulses.
REQ-023 Assert rst at idx 80 -> all outputs to reset values, dma_active 0, no oam_wr until next FF46 write; FF46 reads 8'h00.
